// File: rtl/board_io_pkg.sv
// Shared board I/O definitions: debouncer state encoding and timing constants.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package board_io_pkg;

    typedef enum logic [1:0] {
        DB_IDLE_LOW  = 2'd0,
        DB_WAIT_HIGH = 2'd1,
        DB_IDLE_HIGH = 2'd2,
        DB_WAIT_LOW  = 2'd3
    } db_state_t;

    // 10 ms at 100 MHz
    localparam int DEBOUNCE_CYCLES_100MHZ = 1_000_000;

endpackage

// File: rtl/bit_sync.sv
// Multi-flop synchronizer for one asynchronous board input.
// Latency: DEPTH cycles from d to q.
// Backpressure: none, samples every cycle.
module bit_sync #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [DEPTH-1:0] ff;

    always_ff @(posedge clk) begin
        if (rst) begin
            ff <= '0;
        end else begin
            ff <= {ff[DEPTH-2:0], d};
        end
    end

    assign q = ff[DEPTH-1];

endmodule

// File: rtl/button_debouncer.sv
// Push-button debouncer: clean level plus one-cycle press/release strobes.
// Latency: outputs change SYNC_STAGES + STABLE_CYCLES edges after a held input change.
// Backpressure: none; strobes are fire-and-forget single-cycle pulses.
module button_debouncer
    import board_io_pkg::*;
#(
    parameter int STABLE_CYCLES = DEBOUNCE_CYCLES_100MHZ,
    parameter int SYNC_STAGES   = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    // cnt holds samples already seen; the edge that sees cnt == LAST adds the final one.
    localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);

    logic          s;
    db_state_t     state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic          level_d, press_d, release_d;

    bit_sync #(.DEPTH(SYNC_STAGES)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (btn_in),
        .q   (s)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= DB_IDLE_LOW;
            cnt           <= '0;
            btn_level     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            state         <= state_d;
            cnt           <= cnt_d;
            btn_level     <= level_d;
            press_pulse   <= press_d;
            release_pulse <= release_d;
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = '0;
        unique case (state)
            DB_IDLE_LOW: begin
                if (s) begin
                    if (STABLE_CYCLES == 1) begin
                        state_d = DB_IDLE_HIGH;
                    end else begin
                        state_d = DB_WAIT_HIGH;
                        cnt_d   = CW'(1);
                    end
                end
            end
            DB_WAIT_HIGH: begin
                if (!s) begin
                    state_d = DB_IDLE_LOW;
                end else if (cnt == LAST) begin
                    state_d = DB_IDLE_HIGH;
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end
            DB_IDLE_HIGH: begin
                if (!s) begin
                    if (STABLE_CYCLES == 1) begin
                        state_d = DB_IDLE_LOW;
                    end else begin
                        state_d = DB_WAIT_LOW;
                        cnt_d   = CW'(1);
                    end
                end
            end
            DB_WAIT_LOW: begin
                if (s) begin
                    state_d = DB_IDLE_HIGH;
                end else if (cnt == LAST) begin
                    state_d = DB_IDLE_LOW;
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end
        endcase
    end

    // Aborted waits return to their IDLE state without a strobe.
    always_comb begin
        level_d   = (state_d == DB_IDLE_HIGH) || (state_d == DB_WAIT_LOW);
        press_d   = (state_d == DB_IDLE_HIGH) &&
                    ((state == DB_IDLE_LOW) || (state == DB_WAIT_HIGH));
        release_d = (state_d == DB_IDLE_LOW) &&
                    ((state == DB_IDLE_HIGH) || (state == DB_WAIT_LOW));
    end

endmodule

// File: tb/tb_button_debouncer.sv
// Scoreboard bench: stimulus queues expected strobes with their edge numbers,
// a negedge monitor pops them as the DUTs pulse and tracks the expected level.
module tb_button_debouncer;

    typedef struct {
        int   id;
        logic press;
        int   cyc;
    } ev_t;

    logic clk;
    logic rst;
    logic btn_a, btn_b;
    logic lvl_a, prs_a, rel_a;
    logic lvl_b, prs_b, rel_b;
    logic rst_q;
    int   cyc;
    int   checks;
    int   errors;
    logic exp_lvl [2];
    ev_t  sb [$];

    button_debouncer #(.STABLE_CYCLES(4), .SYNC_STAGES(2)) dut_a (
        .clk           (clk),
        .rst           (rst),
        .btn_in        (btn_a),
        .btn_level     (lvl_a),
        .press_pulse   (prs_a),
        .release_pulse (rel_a)
    );

    button_debouncer #(.STABLE_CYCLES(1), .SYNC_STAGES(2)) dut_b (
        .clk           (clk),
        .rst           (rst),
        .btn_in        (btn_b),
        .btn_level     (lvl_b),
        .press_pulse   (prs_b),
        .release_pulse (rel_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc   = 0;
        rst_q = 1'b1;
    end

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst;
    end

    task automatic fail(input string name, input int id, input int got, input int want);
        errors++;
        $display("FAIL %s dut%0d edge %0d: got %0d, expected %0d", name, id, cyc, got, want);
    endtask

    task automatic expect_ev(input int id, input logic press, input int at);
        ev_t e;
        e.id    = id;
        e.press = press;
        e.cyc   = at;
        sb.push_back(e);
    endtask

    task automatic mon_dut(input int id, input logic l, input logic p, input logic r);
        ev_t e;
        if (rst_q) exp_lvl[id] = 1'b0;
        if (p || r) begin
            checks++;
            if (p && r) begin
                fail("both_pulses", id, 1, 0);
            end else if (sb.size() == 0) begin
                fail("unexpected_pulse_press", id, int'(p), -1);
            end else begin
                e = sb.pop_front();
                if (e.id != id || e.press != p || e.cyc != cyc) begin
                    fail("pulse_edge", id, cyc, e.cyc);
                    fail("pulse_kind_press", id, int'(p), int'(e.press));
                end
                exp_lvl[id] = e.press;
            end
        end else if (sb.size() != 0 && sb[0].id == id && sb[0].cyc < cyc) begin
            checks++;
            e = sb.pop_front();
            fail("missed_pulse_edge", id, cyc, e.cyc);
            exp_lvl[id] = e.press;
        end
        checks++;
        if (l !== exp_lvl[id]) fail("btn_level", id, int'(l), int'(exp_lvl[id]));
    endtask

    always @(negedge clk) begin
        mon_dut(0, lvl_a, prs_a, rel_a);
        mon_dut(1, lvl_b, prs_b, rel_b);
    end

    initial begin
        int   k;
        logic pat [5];
        pat        = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        checks     = 0;
        errors     = 0;
        exp_lvl[0] = 1'b0;
        exp_lvl[1] = 1'b0;
        rst        = 1'b1;
        btn_a      = 1'b0;
        btn_b      = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // clean press, then release
        k = cyc; btn_a = 1'b1; expect_ev(0, 1'b1, k + 6);
        repeat (20) @(negedge clk);
        k = cyc; btn_a = 1'b0; expect_ev(0, 1'b0, k + 6);
        repeat (20) @(negedge clk);

        // bounce 1,0,1,1,0 then hold high
        k = cyc;
        for (int i = 0; i < 5; i++) begin
            btn_a = pat[i];
            @(negedge clk);
        end
        btn_a = 1'b1; expect_ev(0, 1'b1, k + 11);
        repeat (20) @(negedge clk);
        k = cyc; btn_a = 1'b0; expect_ev(0, 1'b0, k + 6);
        repeat (20) @(negedge clk);

        // 3-cycle glitch is swallowed
        btn_a = 1'b1;
        repeat (3) @(negedge clk);
        btn_a = 1'b0;
        repeat (15) @(negedge clk);

        // 4-cycle glitch is accepted both ways
        k = cyc; btn_a = 1'b1;
        expect_ev(0, 1'b1, k + 6);
        expect_ev(0, 1'b0, k + 10);
        repeat (4) @(negedge clk);
        btn_a = 1'b0;
        repeat (15) @(negedge clk);

        // reset on edge 4 of a press; button stays held
        k = cyc; btn_a = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; expect_ev(0, 1'b1, k + 10);
        repeat (20) @(negedge clk);
        k = cyc; btn_a = 1'b0; expect_ev(0, 1'b0, k + 6);
        repeat (20) @(negedge clk);

        // STABLE_CYCLES = 1 with a one-cycle input pulse
        k = cyc; btn_b = 1'b1;
        expect_ev(1, 1'b1, k + 3);
        expect_ev(1, 1'b0, k + 4);
        @(negedge clk);
        btn_b = 1'b0;
        repeat (10) @(negedge clk);

        checks++;
        if (sb.size() != 0) fail("pending_events", -1, sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
